// File: rtl/wall_map.sv
// Wall bitmap for the playfield: boot-time pattern fill, registered display read port,
// single-cycle collision query port and a small break-request queue drained between scans.
module wall_map #(
    parameter int WIDTH       = 64,
    parameter int GAME_HEIGHT = 44,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_state,
    input  logic       i_buzy,
    input  logic [5:0] i_vga_x,
    input  logic [5:0] i_vga_y,
    output logic       o_vga_is_wall,
    input  logic       i_query_valid,
    input  logic [5:0] i_query_x,
    input  logic [5:0] i_query_y,
    output logic       o_query_ready,
    output logic       o_query_valid,
    output logic       o_query_is_wall,
    input  logic       i_break_valid,
    input  logic [5:0] i_break_x,
    input  logic [5:0] i_break_y,
    output logic       o_break_ready,
    output logic       o_map_ready
);
    // state | meaning
    // IDLE  | not in game; waiting for i_state to enter game
    // INIT  | writing the default wall pattern, one cell per cycle
    // READY | map in service: display reads, queries, break drain
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] INIT  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    localparam logic [1:0] GAME_ST = 2'b01;
    localparam int CELLS = WIDTH * GAME_HEIGHT;
    localparam int AW    = $clog2(CELLS);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    function automatic logic [AW-1:0] cell_idx(input logic [5:0] x, input logic [5:0] y);
        return AW'(int'(y) * WIDTH + int'(x));
    endfunction

    function automatic logic in_field(input logic [5:0] x, input logic [5:0] y);
        return (int'(y) < GAME_HEIGHT) && (int'(x) < WIDTH);
    endfunction

    function automatic logic is_border(input logic [5:0] x, input logic [5:0] y);
        return (x == 6'd0) || (int'(x) == WIDTH - 1) || (y == 6'd0) || (int'(y) == GAME_HEIGHT - 1);
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic          mem [CELLS];
    logic [1:0]    state;
    logic [AW-1:0] init_idx;
    logic [5:0]    init_x;
    logic [5:0]    init_y;
    logic          init_wall;
    logic          in_game;

    logic [5:0]    fifo_x [FIFO_DEPTH];
    logic [5:0]    fifo_y [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [5:0]    head_x;
    logic [5:0]    head_y;
    logic          q_accept;

    assign in_game   = (i_state == GAME_ST);
    assign init_wall = is_border(init_x, init_y) || ((init_x[2:0] == 3'd4) && (init_y[2:0] == 3'd4));

    assign o_map_ready   = (state == READY);
    assign o_query_ready = o_map_ready;
    // Readiness is from the registered count only, so a same-cycle pop never frees a full queue.
    assign o_break_ready = (state == READY) && (count < CW'(FIFO_DEPTH));

    assign push     = i_break_valid && o_break_ready;
    assign pop      = (state == READY) && in_game && !i_buzy && (count != '0);
    assign head_x   = fifo_x[rd_ptr];
    assign head_y   = fifo_y[rd_ptr];
    assign q_accept = i_query_valid && o_query_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            init_idx <= '0;
            init_x   <= '0;
            init_y   <= '0;
        end else if (!in_game) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state    <= INIT;
                    init_idx <= '0;
                    init_x   <= '0;
                    init_y   <= '0;
                end
                INIT: begin
                    if (init_idx == AW'(CELLS - 1)) begin
                        state <= READY;
                    end else begin
                        init_idx <= init_idx + AW'(1);
                        if (int'(init_x) == WIDTH - 1) begin
                            init_x <= '0;
                            init_y <= init_y + 6'd1;
                        end else begin
                            init_x <= init_x + 6'd1;
                        end
                    end
                end
                READY:   state <= READY;
                default: state <= IDLE;
            endcase
        end
    end

    // Map storage has no reset; contents are rebuilt by INIT on every game entry.
    always_ff @(posedge clk) begin
        if (!rst && in_game) begin
            if (state == INIT) begin
                mem[init_idx] <= init_wall;
            end else if (pop && in_field(head_x, head_y) && !is_border(head_x, head_y)) begin
                mem[cell_idx(head_x, head_y)] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vga_is_wall   <= 1'b0;
            o_query_valid   <= 1'b0;
            o_query_is_wall <= 1'b0;
        end else begin
            o_vga_is_wall   <= (state == READY) && in_field(i_vga_x, i_vga_y) &&
                               mem[cell_idx(i_vga_x, i_vga_y)];
            o_query_valid   <= q_accept;
            o_query_is_wall <= q_accept && (!in_field(i_query_x, i_query_y) ||
                                            mem[cell_idx(i_query_x, i_query_y)]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !in_game) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_x[wr_ptr] <= i_break_x;
                fifo_y[wr_ptr] <= i_break_y;
                wr_ptr         <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule
